// File: rtl/mvau_pkg.sv
// Shared MVAU definitions: width helpers and the macro that builds the
// parameter-dependent buffer entry type inside each user module.
package mvau_pkg;

    // Counter width for a modulus n; never narrower than one bit.
    function automatic int cnt_width_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`define MVAU_ENTRY_T(W) struct packed { logic last; logic [(W)-1:0] data; }

// File: rtl/mvau_stream_out_ctrl_if.sv
// Accumulator-in / stream-out bus of the MVAU output controller.
interface mvau_stream_out_ctrl_if #(
    parameter int PE    = 2,
    parameter int TDstI = 16
);
    logic                  acc_v;
    logic [PE*TDstI-1:0]   acc_in;
    logic                  out_rready;
    logic                  out_v;
    logic [PE*TDstI-1:0]   out;
    logic                  out_last;
    logic                  wait_rready;

    modport master (
        input  acc_v, acc_in, out_rready,
        output out_v, out, out_last, wait_rready
    );

    modport slave (
        output acc_v, acc_in, out_rready,
        input  out_v, out, out_last, wait_rready
    );
endinterface

// File: rtl/mvau_out_fifo.sv
// Register-array circular buffer; the caller only asserts push when it may
// be accepted and pop only when the buffer holds data.
module mvau_out_fifo #(
    parameter int W       = 33,
    parameter int DEPTH   = 4,
    parameter int DEPTH_T = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [DEPTH_T:0] count,
    output logic             full
);
    localparam logic [DEPTH_T:0] DEPTH_C = (DEPTH_T+1)'(DEPTH);

    logic [W-1:0]       mem_q [DEPTH];
    logic [W-1:0]       mem_d [DEPTH];
    logic [DEPTH_T-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_T-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_T:0]   count_q, count_d;

    // Next-state for storage, pointers and occupancy; pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + DEPTH_T'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_T'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (DEPTH_T+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_T+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == DEPTH_C);
endmodule

// File: rtl/mvau_stream_out_ctrl.sv
// MVAU output controller: buffers each accumulator vector, tags the last
// fold of an NF sweep and streams entries out with valid/ready.
module mvau_stream_out_ctrl
    import mvau_pkg::*;
#(
    parameter int PE      = 2,
    parameter int TDstI   = 16,
    parameter int NF      = 4,
    parameter int NF_T    = 2,
    parameter int DEPTH   = 4,
    parameter int DEPTH_T = 2
) (
    input  logic                   aclk,
    input  logic                   areset,
    mvau_stream_out_ctrl_if.master bus,
    output logic                   buf_full,
    output logic                   ovf
);
    typedef `MVAU_ENTRY_T(PE*TDstI) entry_t;

    localparam logic [NF_T-1:0] NF_LAST = NF_T'(NF-1);

    entry_t             din_s;
    entry_t             dout_s;
    logic [DEPTH_T:0]   count_s;
    logic               full_s;
    logic               pop_s;
    logic               accept_s;
    logic [NF_T-1:0]    nf_cnt_q, nf_cnt_d;
    logic               ovf_q, ovf_d;

    // A full buffer still takes a push when an entry leaves in the same cycle.
    always_comb begin
        pop_s        = bus.out_v & bus.out_rready;
        accept_s     = bus.acc_v & (~full_s | pop_s);
        din_s.last   = (nf_cnt_q == NF_LAST);
        din_s.data   = bus.acc_in;
        nf_cnt_d     = nf_cnt_q;
        if (accept_s) begin
            nf_cnt_d = (nf_cnt_q == NF_LAST) ? '0 : nf_cnt_q + NF_T'(1);
        end else begin
            nf_cnt_d = nf_cnt_q;
        end
        ovf_d = ovf_q | (bus.acc_v & ~accept_s);
    end

    // Fold counter and sticky overflow flag.
    always_ff @(posedge aclk) begin
        if (areset) begin
            nf_cnt_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            nf_cnt_q <= nf_cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    mvau_out_fifo #(
        .W       ($bits(entry_t)),
        .DEPTH   (DEPTH),
        .DEPTH_T (DEPTH_T)
    ) u_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (accept_s),
        .pop   (pop_s),
        .din   (din_s),
        .dout  (dout_s),
        .count (count_s),
        .full  (full_s)
    );

    assign bus.out_v       = (count_s != '0);
    assign bus.out         = dout_s.data;
    assign bus.out_last    = dout_s.last;
    assign bus.wait_rready = bus.out_v & ~bus.out_rready;
    assign buf_full        = full_s;
    assign ovf             = ovf_q;
endmodule

// File: tb/tb_mvau_stream_out_ctrl.sv
// Directed and randomized bench for mvau_stream_out_ctrl against a queue model.
module tb_mvau_stream_out_ctrl;
    localparam int PE = 2, TDSTI = 16, W = PE*TDSTI, NF = 4, DEPTH = 4;

    logic aclk = 1'b0;
    logic areset;
    logic buf_full, ovf;
    int   checks = 0;
    int   errors = 0;
    bit   check_en = 1'b0;

    // model state: bit W is the last tag
    logic [W:0] mq[$];
    int         m_nf = 0;
    bit         m_ovf = 1'b0;

    mvau_stream_out_ctrl_if #(.PE(PE), .TDstI(TDSTI)) bus ();

    mvau_stream_out_ctrl #(
        .PE(PE), .TDstI(TDSTI), .NF(NF), .NF_T(2), .DEPTH(DEPTH), .DEPTH_T(2)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .bus      (bus),
        .buf_full (buf_full),
        .ovf      (ovf)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [W-1:0] f;
        if (check_en) begin
            chk("out_v", W'(bus.out_v), W'(mq.size() != 0));
            chk("buf_full", W'(buf_full), W'(mq.size() == DEPTH));
            chk("wait_rready", W'(bus.wait_rready), W'((mq.size() != 0) && !bus.out_rready));
            chk("ovf", W'(ovf), W'(m_ovf));
            if (mq.size() != 0) begin
                f = mq[0][W-1:0];
                chk("out_data", bus.out, f);
                chk("out_last", W'(bus.out_last), W'(mq[0][W]));
            end
        end
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit rst);
        @(negedge aclk);
        bus.acc_v      = v;
        bus.acc_in     = d;
        bus.out_rready = r;
        areset         = rst;
        #1;
        check_model();
    endtask

    task automatic tick();
        bit pop;
        bit acc;
        @(posedge aclk);
        if (areset) begin
            mq.delete();
            m_nf  = 0;
            m_ovf = 1'b0;
        end else begin
            pop = (mq.size() != 0) && bus.out_rready;
            acc = bus.acc_v && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back({(m_nf == NF-1) ? 1'b1 : 1'b0, bus.acc_in});
                m_nf = (m_nf + 1) % NF;
            end else if (bus.acc_v) begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic step(input bit v, input logic [W-1:0] d, input bit r, input bit rst);
        drive(v, d, r, rst);
        tick();
    endtask

    initial begin
        int lasts;
        bus.acc_v = 1'b0; bus.acc_in = '0; bus.out_rready = 1'b0; areset = 1'b1;
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        check_en = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0);

        // single result
        step(1'b1, 32'h0001_0002, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("single_valid", W'(bus.out_v), 32'd1);
        chk("single_data", bus.out, 32'h0001_0002);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("single_empty", W'(bus.out_v), 32'd0);
        tick();

        // NF tagging: fresh sweep after reset, 8 pushes, lasts on 4th and 8th
        step(1'b0, '0, 1'b1, 1'b1);
        lasts = 0;
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
            if (i >= 1 && i <= 8) begin
                chk("nf_last", W'(bus.out_last), W'(i == 4 || i == 8));
                lasts += int'(bus.out_last);
            end
            tick();
        end
        chk("nf_last_count", W'(lasts), 32'd2);

        // back-pressure: fill, hold, then drain with no bubbles
        for (int i = 0; i < 4; i++) step(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("bp_full", W'(buf_full), 32'd1);
        chk("bp_wait", W'(bus.wait_rready), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            chk("bp_order", bus.out, 32'hB000_0000 + 32'(i));
            tick();
        end

        // simultaneous push/pop while full, then while empty
        for (int i = 0; i < 4; i++) step(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'hC000_0004, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("sim_full_cnt", W'(buf_full), 32'd1);
        chk("sim_full_ovf", W'(ovf), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'hC000_0005, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("sim_empty_v", W'(bus.out_v), 32'd1);
        chk("sim_empty_data", bus.out, 32'hC000_0005);
        tick();
        step(1'b0, '0, 1'b1, 1'b0);

        // overflow: fifth push while full is dropped, flag sticks
        for (int i = 0; i < 5; i++) step(1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("ovf_set", W'(ovf), 32'd1);
        tick();
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("ovf_sticky", W'(ovf), 32'd1);
        chk("ovf_dropped", W'(bus.out_v), 32'd0);
        tick();

        // reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("rst_outv", W'(bus.out_v), 32'd0);
        chk("rst_ovf", W'(ovf), 32'd0);
        tick();
        step(1'b1, 32'hE000_00FF, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("rst_data", bus.out, 32'hE000_00FF);
        chk("rst_last", W'(bus.out_last), 32'd0);
        tick();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
